// File: rtl/btn_evt_pkg.sv
// Shared types and helpers for the button event queue.
package btn_evt_pkg;

  localparam int NUM_BTN_DEFAULT = 8;

  typedef enum logic [2:0] {
    BTN_A      = 3'd0,
    BTN_B      = 3'd1,
    BTN_UP     = 3'd2,
    BTN_DOWN   = 3'd3,
    BTN_LEFT   = 3'd4,
    BTN_RIGHT  = 3'd5,
    BTN_START  = 3'd6,
    BTN_SELECT = 3'd7
  } btn_code_e;

  // One-hot of the lowest set bit (zero when v is zero).
  function automatic logic [31:0] lsb_onehot(
    input logic [31:0] v
  );
    return v & (~v + 32'd1);
  endfunction

endpackage

// File: rtl/evt_fifo.sv
// Small event FIFO with wrap-bit pointers; head is read straight from storage.
module evt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 3,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_din,
  input  logic          i_pop,
  output logic [W-1:0]  o_head,
  output logic          o_valid,
  output logic          o_full,
  output logic [AW:0]   o_count
);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_rd;
  logic [AW:0]  r_wr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd <= '0;
      r_wr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_push) begin
        r_mem[r_wr[AW-1:0]] <= i_din;
        r_wr <= r_wr + 1'b1;
      end
      if (i_pop) begin
        r_rd <= r_rd + 1'b1;
      end
    end
  end

  assign o_head  = r_mem[r_rd[AW-1:0]];
  assign o_valid = (r_rd != r_wr);
  assign o_full  = (r_rd[AW] != r_wr[AW]) &&
                   (r_rd[AW-1:0] == r_wr[AW-1:0]);
  assign o_count = r_wr - r_rd;

endmodule

// File: rtl/button_event_queue.sv
// Serialises button press pulses into a popped event queue.
// Optional BTN_EVT_COALESCE_EN: at most one queued event per button.
module button_event_queue
  import btn_evt_pkg::*;
#(
  parameter int NUM_BTN = NUM_BTN_DEFAULT,
  parameter int DEPTH   = 4,
  localparam int CW     = $clog2(NUM_BTN),
  localparam int CNTW   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] pressed,
  output logic               evt_valid,
  output logic [CW-1:0]      evt_code,
  input  logic               evt_ready,
  output logic [CNTW-1:0]    evt_count,
  output logic               ovf,
  input  logic               ovf_clr
);

  logic [NUM_BTN-1:0] r_pending;
  logic [NUM_BTN-1:0] w_cand;
  logic [NUM_BTN-1:0] w_xfer;
  logic [CW-1:0]      w_code;
  logic               w_full;
  logic               w_pop;
  logic               w_push_ok;
  logic               w_push;
  logic               w_lost;

  assign w_pop     = evt_valid & evt_ready;
  assign w_push_ok = ~w_full | w_pop;

`ifdef BTN_EVT_COALESCE_EN
  logic [NUM_BTN-1:0] r_inq;
  logic [NUM_BTN-1:0] w_pop_oh;

  always_comb begin
    w_pop_oh = '0;
    if (w_pop) w_pop_oh[evt_code] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_inq <= '0;
    else          r_inq <= (r_inq & ~w_pop_oh) | w_xfer;
  end

  assign w_cand = r_pending & ~r_inq;
`else
  assign w_cand = r_pending;
`endif

  always_comb begin
    w_xfer = '0;
    if (w_push_ok) w_xfer = NUM_BTN'(lsb_onehot(32'(w_cand)));
    w_code = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (w_xfer[i]) w_code = CW'(i);
    end
  end

  assign w_push = |w_xfer;
  // A press only counts as lost if its pending bit is not leaving now.
  assign w_lost = |(pressed & r_pending & ~w_xfer);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
      ovf       <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_xfer) | pressed;
      if (w_lost)       ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  evt_fifo #(
    .DEPTH (DEPTH),
    .W     (CW)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_push  (w_push),
    .i_din   (w_code),
    .i_pop   (w_pop),
    .o_head  (evt_code),
    .o_valid (evt_valid),
    .o_full  (w_full),
    .o_count (evt_count)
  );

endmodule
